// File: rtl/uart_line_monitor.sv
// -----------------------------------------------------------------------------
// uart_line_monitor
//
// Oversampling UART receiver that watches a serial line (idle high), decodes
// 8N1 frames into bytes and queues them in a first-word-fall-through FIFO
// drained through a valid/ready port. Framing errors, break conditions and
// FIFO overflow are flagged for console checkers.
//
// Optional feature: define UART_MON_PARITY_EN to receive 8E1 frames. This adds
// a parity state after data bit 7 and the sticky output parity_err_o. Frames
// with a parity mismatch are not queued; the stop bit is still checked.
//
// Parameters
//   CLKS_PER_BIT  clk_i cycles per bit (>= 8)
//   FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i         in   1  clock, rising edge
//   rst_i         in   1  asynchronous active-high reset
//   rx_i          in   1  serial line, asynchronous to clk_i
//   byte_o        out  8  FIFO head byte (0 while the FIFO is empty)
//   valid_o       out  1  FIFO non-empty
//   ready_i       in   1  pops the head when valid_o & ready_i
//   frame_err_o   out  1  one-cycle pulse: stop bit sampled low
//   break_o       out  1  break seen, held until the line samples high
//   overflow_o    out  1  sticky: byte dropped because the FIFO was full
//   parity_err_o  out  1  (UART_MON_PARITY_EN only) sticky parity mismatch
//   clr_i         in   1  synchronous clear of the sticky flags
// -----------------------------------------------------------------------------
module uart_line_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       overflow_o,
`ifdef UART_MON_PARITY_EN
    output logic       parity_err_o,
`endif
    input  logic       clr_i
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Sample points: mid start bit (re-checks the start edge), then one full
    // bit period later for every following bit, which lands mid-bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ---- stage p0/p1: two-flop synchronizer; p2 holds the previous rxs ----
    logic rx_p0;
    logic rxs_p1;
    logic rxs_p2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_p0  <= 1'b1;
            rxs_p1 <= 1'b1;
            rxs_p2 <= 1'b1;
        end else begin
            rx_p0  <= rx_i;
            rxs_p1 <= rx_p0;
            rxs_p2 <= rxs_p1;
        end
    end

    // ---- frame decoder ----
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_tick;
    logic             push;

    assign bit_tick = (cnt == CNT_LAST);

`ifdef UART_MON_PARITY_EN
    logic par_bad;
    assign push = (state == ST_STOP) && bit_tick && rxs_p1 && !par_bad;
`else
    assign push = (state == ST_STOP) && bit_tick && rxs_p1;
`endif

    // Data shift register carries no reset: it is fully reloaded by every
    // frame before it is pushed or inspected for a break.
    always_ff @(posedge clk_i) begin
        if (state == ST_DATA && bit_tick) begin
            shreg <= {rxs_p1, shreg[7:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            frame_err_o <= 1'b0;
            break_o     <= 1'b0;
`ifdef UART_MON_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a line
                    // stuck low after a framing error is not re-decoded.
                    if (rxs_p2 && !rxs_p1) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs_p1 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_MON_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= (^shreg) ^ rxs_p1;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (rxs_p1) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            // All-zero data with a low stop bit is a break.
                            if (shreg == 8'h00) begin
                                break_o <= 1'b1;
                                state   <= ST_BREAK;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs_p1) begin
                        break_o <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef UART_MON_PARITY_EN
            // A new mismatch takes priority over a clear in the same cycle.
            if (state == ST_PARITY && bit_tick && ((^shreg) ^ rxs_p1)) begin
                parity_err_o <= 1'b1;
            end else if (clr_i) begin
                parity_err_o <= 1'b0;
            end
`endif
        end
    end

    // ---- byte FIFO ----
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full    = (count == FULL_CNT);
    assign valid_o = (count != '0);
    assign pop     = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign wr_en   = push & (~full | pop);
    assign byte_o  = valid_o ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Set wins over a simultaneous clear.
            if (push && full && !pop) begin
                overflow_o <= 1'b1;
            end else if (clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_line_monitor.sv
`timescale 1ns/1ps
module tb_uart_line_monitor;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       rst_i   = 1'b1;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic       clr_i   = 1'b0;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       break_o;
    logic       overflow_o;
`ifdef UART_MON_PARITY_EN
    logic       parity_err_o;
    logic       par_flip = 1'b0;
`endif

    uart_line_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .byte_o      (byte_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .break_o     (break_o),
        .overflow_o  (overflow_o),
`ifdef UART_MON_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .clr_i       (clr_i)
    );

    always #5 clk = ~clk;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         ready_mode = 0;   // 0: ready low, 1: ready high, 2: random
    int         ferr_seen  = 0;   // frame_err_o pulses observed
    logic [7:0] exp_q[$];         // reference model: bytes the consumer must see, in order
    logic       clr_at_stop = 1'b0;

    // Output snapshots around the stop-bit sample edge of the last frame.
    logic       snap_pre_valid, snap_valid, snap_ferr, snap_brk, snap_post_ferr;
    logic [7:0] snap_byte;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: consumer side checked at the falling edge, inputs moved 1 ns
    // after the rising edge.
    task automatic tick();
        logic [7:0] head;
        @(negedge clk);
        if (!rst_i) begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected: got byte 0x%0h, expected no data", byte_o);
                end else begin
                    head = exp_q.pop_front();
                    chk("pop_byte", {24'h0, byte_o}, {24'h0, head});
                end
            end
            if (frame_err_o) ferr_seen++;
        end
        @(posedge clk);
        #1;
        ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        ticks(n);
    endtask

    // Drives one frame. The stop-bit sample edge is 11 clocks after the stop
    // bit is driven (3 clocks sync/edge detect + half-bit offset).
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_i = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            ticks(CPB);
        end
`ifdef UART_MON_PARITY_EN
        rx_i = (^d) ^ par_flip;
        ticks(CPB);
`endif
        rx_i = stop;
        ticks(CPB - 6);
        snap_pre_valid = valid_o;
        clr_i = clr_at_stop;
        tick();
        clr_i = 1'b0;
        snap_valid = valid_o;
        snap_byte  = byte_o;
        snap_ferr  = frame_err_o;
        snap_brk   = break_o;
        tick();
        snap_post_ferr = frame_err_o;
        ticks(4);
    endtask

    task automatic drain(input string name);
        ready_mode = 1;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
        ticks(2);
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_valid"}, valid_o, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         exp_ferr;
        logic [7:0] d;
        logic       stop;

        tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'hA3, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hA3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h01, 1'b0, 1'b0, 1'b1};

        // Reset state
        ticks(3);
        chk("rst_valid", valid_o, 0);
        chk("rst_byte", byte_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_break", break_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst_i = 1'b0;
        idle(20);

        // Table-driven frames, consumer always ready
        ready_mode = 1;
        tick();
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].exp_valid) exp_q.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop);
            chk($sformatf("t%0d_pre_valid", i), snap_pre_valid, 0);
            chk($sformatf("t%0d_valid", i), snap_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("t%0d_byte", i), snap_byte, tbl[i].data);
            chk($sformatf("t%0d_ferr", i), snap_ferr, tbl[i].exp_ferr);
            chk($sformatf("t%0d_ferr_off", i), snap_post_ferr, 0);
            chk($sformatf("t%0d_break", i), snap_brk, 0);
            idle(8);
        end
        chk("tbl_left", exp_q.size(), 0);

        // Short low glitch: rejected at the mid start-bit check
        base = ferr_seen;
        rx_i = 1'b0;
        ticks(4);
        idle(40);
        chk("glitch_valid", valid_o, 0);
        chk("glitch_ferr", ferr_seen - base, 0);
        chk("glitch_break", break_o, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        chk("post_glitch_valid", snap_valid, 1);
        chk("post_glitch_byte", snap_byte, 8'h3C);
        idle(8);

        // Break: line low for 20 bit times
        base = ferr_seen;
        send_frame(8'h00, 1'b0);
        chk("brk_ferr", snap_ferr, 1);
        chk("brk_set", snap_brk, 1);
        chk("brk_valid", snap_valid, 0);
        chk("brk_ferr_off", snap_post_ferr, 0);
        ticks(10 * CPB);
        chk("brk_hold", break_o, 1);
        rx_i = 1'b1;
        ticks(2);
        chk("brk_still_2", break_o, 1);
        tick();
        chk("brk_clear_3", break_o, 0);
        chk("brk_ferr_count", ferr_seen - base, 1);
        idle(8);
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        chk("post_brk_valid", snap_valid, 1);
        chk("post_brk_byte", snap_byte, 8'h41);
        idle(8);

        // Overflow: 17 bytes with no consumer; clear coincides with the drop
        ready_mode = 0;
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            clr_at_stop = (i == DEPTH);
            send_frame(8'(i), 1'b1);
            clr_at_stop = 1'b0;
            if (i == DEPTH - 1) chk("ovf_before", overflow_o, 0);
            idle(4);
        end
        chk("ovf_set", overflow_o, 1);
        chk("ovf_head_valid", valid_o, 1);
        chk("ovf_head_byte", byte_o, 8'h00);
        drain("ovf_drain");
        chk("ovf_sticky", overflow_o, 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        chk("ovf_cleared", overflow_o, 0);

`ifdef UART_MON_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        ready_mode = 1;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        chk("par_err_set", parity_err_o, 1);
        chk("par_bad_valid", snap_valid, 0);
        chk("par_bad_ferr", snap_ferr, 0);
        idle(8);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        chk("par_err_clr", parity_err_o, 0);
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        chk("par_ok_valid", snap_valid, 1);
        chk("par_ok_byte", snap_byte, 8'h07);
        chk("par_ok_flag", parity_err_o, 0);
        idle(8);
`endif

        // Reset mid-frame with bytes queued
        ready_mode = 0;
        tick();
        exp_q.push_back(8'hA1);
        send_frame(8'hA1, 1'b1);
        idle(4);
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, 1'b1);
        idle(4);
        chk("mid_queued", valid_o, 1);
        base = ferr_seen;
        rx_i = 1'b0;
        ticks(60);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_byte", byte_o, 0);
        chk("mid_rst_ferr", frame_err_o, 0);
        chk("mid_rst_break", break_o, 0);
        rst_i = 1'b0;
        ready_mode = 1;
        idle(40);
        chk("mid_after_valid", valid_o, 0);
        chk("mid_after_ferr", ferr_seen - base, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        chk("mid_next_byte", snap_byte, 8'h5A);
        idle(8);

        // Randomized frames, random consumer readiness
        ready_mode = 2;
        base = ferr_seen;
        exp_ferr = 0;
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if (!stop && d == 8'h00) stop = 1'b1;
            if (stop) exp_q.push_back(d);
            else exp_ferr++;
            send_frame(d, stop);
            chk($sformatf("rnd%0d_ferr", i), snap_ferr, !stop);
            idle($urandom_range(4, 20));
        end
        drain("rnd_drain");
        chk("rnd_ferr_count", ferr_seen - base, exp_ferr);
        chk("rnd_ovf", overflow_o, 0);
        chk("rnd_break", break_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
